// File: rtl/regfile_pkg.sv
// Shared register-file constants and word type, used by the write side
// and the read-mux side of the datapath.
package regfile_pkg;

    localparam int unsigned DATA_W   = 64;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned ZERO_REG = 31;

    typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/regfile_write_decoder5_32.sv
// 5-to-32 enabled one-hot decoder: a 2-to-4 stage on in[4:3] selects one
// of four 3-to-8 banks decoding in[2:0]. With en low every output is 0,
// whatever the value of in.
module decoder5_32 (
    output logic [31:0] out,
    input  logic [4:0]  in,
    input  logic        en
);

    logic [3:0] bank_en;

    // 2-to-4 stage: enable exactly one bank of eight outputs
    always_comb begin
        bank_en = '0;
        if (en) begin
            bank_en[in[4:3]] = 1'b1;
        end
    end

    // 3-to-8 stages: each enabled bank drives one of its eight outputs
    always_comb begin
        out = '0;
        for (int unsigned b = 0; b < 4; b++) begin
            if (bank_en[b]) begin
                out[b*8 +: 8] = 8'b0000_0001 << in[2:0];
            end
        end
    end

endmodule

// File: rtl/regfile_write.sv
// Write side of the 32 x 64-bit register file. One register is written per
// strobed edge; the zero register has no storage and always reads 0. All
// register contents are exported for the read muxes.
module regfile_write
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = regfile_pkg::DATA_W,
    parameter int unsigned NUM_REGS = regfile_pkg::NUM_REGS,
    parameter int unsigned ADDR_W   = regfile_pkg::ADDR_W,
    parameter int unsigned ZERO_REG = regfile_pkg::ZERO_REG
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WriteRegister,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] regs [NUM_REGS]
);

    logic [NUM_REGS-1:0] wr_en;

    // RegWrite gates the decoder so an unknown address cannot reach any enable
    decoder5_32 u_decoder (
        .out (wr_en),
        .in  (WriteRegister),
        .en  (RegWrite)
    );

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
        if (r == ZERO_REG) begin : g_zero
            // Writes decoded to the zero register are dropped here
            logic unused_zero_en;
            assign unused_zero_en = wr_en[r];
            assign regs[r]        = '0;
        end else begin : g_store
            logic [DATA_W-1:0] reg_d;
            logic [DATA_W-1:0] reg_q;

            // Load new data when enabled, otherwise hold via feedback
            always_comb begin
                reg_d = reg_q;
                if (wr_en[r]) begin
                    reg_d = WriteData;
                end
            end

            // Register state with asynchronous clear
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    reg_q <= '0;
                end else begin
                    reg_q <= reg_d;
                end
            end

            assign regs[r] = reg_q;
        end
    end

endmodule
